// File: rtl/rv32i_mem_responder.sv
// rv32i_mem_responder: memory-side responder for the RV32i core.
// Instruction port: registered wait-state FSM with a fetch-valid pulse.
// Data port: word array with byte-lane writes and combinational reads.
// Optional checking is enabled by defining RV32I_MEM_ERR_EN, which adds mem_err_o.
module rv32i_mem_responder #(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter int unsigned IMEM_WAIT  = 0,
  parameter string       IMEM_INIT  = "imem.hex",
  parameter string       DMEM_INIT  = ""
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [31:0] imem_add_i,
  output logic [31:0] imem_data_o,
  output logic        imem_valid_o,
  input  logic [31:0] dmem_add_i,
  input  logic [31:0] dmem_di_i,
  input  logic        dmem_we_i,
  input  logic        dmem_re_i,
  input  logic [3:0]  dmem_ble_i,
  output logic [31:0] dmem_do_o
`ifdef RV32I_MEM_ERR_EN
  ,
  output logic        mem_err_o
`endif
);

  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [3:0]  WAIT_LOAD = 4'(IMEM_WAIT);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];

  state_e      state_q;
  logic [31:0] req_addr_q;
  logic [3:0]  cnt_q;

  logic [IAW-1:0] req_idx;
  logic [DAW-1:0] d_idx;
  logic           redirect;
  logic           wr_en;

  assign req_idx  = req_addr_q[IAW+1:2];
  assign d_idx    = dmem_add_i[DAW+1:2];
  // Core moved its fetch address while we were still waiting on the old one.
  assign redirect = (state_q == StWait) && (imem_add_i != req_addr_q);

`ifdef RV32I_MEM_ERR_EN
  logic fetch_bad;
  logic fetch_latch;
  logic d_range_bad;
  logic ble_bad;
  logic err_set;
  logic err_q;
  logic unused_daddr;

  assign fetch_bad   = (imem_add_i[1:0] != 2'b00) || (|imem_add_i[31:IAW+2]);
  assign fetch_latch = (state_q == StIdle) || redirect;
  assign d_range_bad = |dmem_add_i[31:DAW+2];
  assign unused_daddr = ^dmem_add_i[1:0];

  // Only single bytes, aligned halves and full words are legal lane patterns.
  always_comb begin
    ble_bad = 1'b1;
    case (dmem_ble_i)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: ble_bad = 1'b0;
      default: ble_bad = 1'b1;
    endcase
  end

  assign err_set = (fetch_latch && fetch_bad) ||
                   ((dmem_we_i || dmem_re_i) && d_range_bad) ||
                   (dmem_we_i && ble_bad);
  assign wr_en   = dmem_we_i && !d_range_bad && !ble_bad;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign mem_err_o = err_q;

  // Combinational read; out-of-range reads return a marker value.
  always_comb begin
    dmem_do_o = 32'h0;
    if (dmem_re_i) begin
      dmem_do_o = d_range_bad ? 32'hDEAD_BEEF : dmem[d_idx];
    end
  end
`else
  logic unused_daddr;

  // Upper address bits wrap and byte-offset bits are ignored.
  assign unused_daddr = ^{dmem_add_i[31:DAW+2], dmem_add_i[1:0]};
  assign wr_en        = dmem_we_i;

  // Combinational read, zero when not enabled.
  always_comb begin
    dmem_do_o = 32'h0;
    if (dmem_re_i) begin
      dmem_do_o = dmem[d_idx];
    end
  end
`endif

  // Byte-lane writes; reads in the same cycle see the old word.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && dmem_ble_i[b]) begin
        dmem[d_idx][8*b +: 8] <= dmem_di_i[8*b +: 8];
      end
    end
  end

  // Fetch FSM: latch address, count wait states, present the word for one cycle.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= StIdle;
      req_addr_q   <= 32'h0;
      cnt_q        <= 4'h0;
      imem_data_o  <= NOP;
      imem_valid_o <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_addr_q <= imem_add_i;
          cnt_q      <= WAIT_LOAD;
          state_q    <= StWait;
        end
        StWait: begin
          if (redirect) begin
            req_addr_q <= imem_add_i;
            cnt_q      <= WAIT_LOAD;
          end else if (cnt_q == 4'h0) begin
            imem_data_o  <= imem[req_idx];
            imem_valid_o <= 1'b1;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'h1;
          end
        end
        StResp: begin
          // A redirect seen here still completes the old fetch; the core flushes it.
          imem_valid_o <= 1'b0;
          state_q      <= StIdle;
        end
        default: begin
          imem_valid_o <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

endmodule
